// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath: steps each instruction
// through fetch/decode/execute/memory/write-back and drives every select and enable.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       se_o,
  output logic [2:0] alu_op_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_SLTIU = 6'b001011,
                         OP_LUI   = 6'b001111, OP_ORI  = 6'b001101, OP_LW    = 6'b100011,
                         OP_SW    = 6'b101011, OP_BEQ  = 6'b000100, OP_BNE   = 6'b000101,
                         OP_BLE   = 6'b000110, OP_BLTZ = 6'b000001, OP_J     = 6'b000010,
                         OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FN = 3'b010,
                         ALU_LUI = 3'b011, ALU_OR = 3'b100, ALU_SLTU = 3'b110;

  state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // I-type ALU setup is shared by EXEC_I and WB_I so the result stays stable during write-back
  logic [2:0] itype_op;
  logic       itype_se;
  always_comb begin
    itype_op = ALU_ADD;
    itype_se = 1'b1;
    case (instr_op_i)
      OP_SLTIU: itype_op = ALU_SLTU;
      OP_LUI:   itype_op = ALU_LUI;
      OP_ORI:   begin itype_op = ALU_OR; itype_se = 1'b0; end
      default:  itype_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    se_o         = 1'b0;
    alu_op_o     = ALU_ADD;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'd0;
    mem_to_reg_o = 2'd0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    state_o      = state_q;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        if (mem_ready_i) begin
          pc_write_o = 1'b1;
          ir_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'd3;
        se_o        = 1'b1;
        case (instr_op_i)
          OP_RTYPE:                        state_d = (funct_i == FN_JR) ? S_JUMP : S_EXEC_R;
          OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                    state_d = S_ADDR;
          OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ: state_d = S_BRANCH;
          OP_J, OP_JAL:                    state_d = S_JUMP;
          default: begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FN;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 2'd1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC_I, S_WB_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = itype_op;
        se_o        = itype_se;
        if (state_q == S_EXEC_I) begin
          state_d = S_WB_I;
        end else begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        se_o        = 1'b1;
        state_d     = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'd1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALU_SUB;
        pc_src_o     = 2'd1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
        case (instr_op_i)
          OP_BEQ:  pc_write_o = zero_i;
          OP_BNE:  pc_write_o = !zero_i;
          OP_BLE:  pc_write_o = zero_i | neg_i;
          OP_BLTZ: pc_write_o = neg_i;
          default: pc_write_o = 1'b0;
        endcase
      end
      S_JUMP: begin
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
        pc_src_o     = (instr_op_i == OP_RTYPE) ? 2'd3 : 2'd2;
        if (instr_op_i == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'd2;
          mem_to_reg_o = 2'd2;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // reset blanks every output so an abandoned instruction cannot strobe anything
    if (rst_i) begin
      pc_write_o   = 1'b0;
      pc_src_o     = 2'd0;
      ir_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'd0;
      se_o         = 1'b0;
      alu_op_o     = 3'd0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 2'd0;
      mem_to_reg_o = 2'd0;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;
      state_o      = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench: per-instruction expected traces built from the instruction class, compared cycle by cycle.
module tb_multicycle_ctrl;

  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] op = '0, fn = '0;
  logic zero = 1'b0, neg = 1'b0, rdy = 1'b1;
  logic pcw, irw, iord, mrd, mwr, a, se, rw, st_done, ill;
  logic [1:0] pcs, b, rd, m2r;
  logic [2:0] aop;
  logic [3:0] st;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .funct_i(fn), .zero_i(zero), .neg_i(neg),
    .mem_ready_i(rdy), .pc_write_o(pcw), .pc_src_o(pcs), .ir_write_o(irw), .iord_o(iord),
    .mem_read_o(mrd), .mem_write_o(mwr), .alu_src_a_o(a), .alu_src_b_o(b), .se_o(se),
    .alu_op_o(aop), .reg_write_o(rw), .reg_dst_o(rd), .mem_to_reg_o(m2r), .state_o(st),
    .instr_done_o(st_done), .illegal_o(ill)
  );

  typedef struct packed {
    logic pcw; logic [1:0] pcs; logic irw, iord, mrd, mwr, a; logic [1:0] b; logic se;
    logic [2:0] aop; logic rw; logic [1:0] rd, m2r; logic [3:0] st; logic done, ill;
  } ov_t;

  ov_t obs;
  assign obs = {pcw, pcs, irw, iord, mrd, mwr, a, b, se, aop, rw, rd, m2r, st, st_done, ill};

  ov_t  exp_q[$];
  logic rdy_q[$];
  int checks = 0, errors = 0, n_instr = 0;

  task automatic check(input string tag, input ov_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s instr%0d observed=%h expected=%h", tag, n_instr, obs, e);
    end
  endtask

  task automatic push(input ov_t e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  // Reference trace for one instruction: fw fetch waits, mw memory waits
  task automatic build(input logic [5:0] o, f, input int fw, mw, input logic z, n);
    ov_t e;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mrd = 1; e.b = 1;
      if (i == fw) begin e.pcw = 1; e.irw = 1; end
      push(e, i == fw);
    end
    e = '0; e.b = 3; e.se = 1; e.st = 1;
    if (o == 6'd0 && f == 6'b001000 || o == 6'b000010 || o == 6'b000011) begin
      push(e, 1'($urandom));
      e = '0; e.pcw = 1; e.done = 1; e.st = 11;
      e.pcs = (o == 6'd0) ? 2'd3 : 2'd2;
      if (o == 6'b000011) begin e.rw = 1; e.rd = 2; e.m2r = 2; end
      push(e, 1'($urandom));
    end else if (o == 6'd0) begin
      push(e, 1'($urandom));
      e = '0; e.a = 1; e.aop = 3'b010; e.st = 2; push(e, 1'($urandom));
      e = '0; e.rw = 1; e.rd = 1; e.done = 1; e.st = 7; push(e, 1'($urandom));
    end else if (o inside {6'b001000, 6'b001011, 6'b001111, 6'b001101}) begin
      push(e, 1'($urandom));
      e = '0; e.a = 1; e.b = 2; e.st = 3; e.se = (o != 6'b001101);
      e.aop = (o == 6'b001011) ? 3'b110 : (o == 6'b001111) ? 3'b011 :
              (o == 6'b001101) ? 3'b100 : 3'b000;
      push(e, 1'($urandom));
      e.rw = 1; e.done = 1; e.st = 8; push(e, 1'($urandom));
    end else if (o == 6'b100011 || o == 6'b101011) begin
      push(e, 1'($urandom));
      e = '0; e.a = 1; e.b = 2; e.se = 1; e.st = 4; push(e, 1'($urandom));
      for (int j = 0; j <= mw; j++) begin
        e = '0; e.iord = 1;
        if (o == 6'b100011) begin e.mrd = 1; e.st = 5; end
        else begin e.mwr = 1; e.st = 6; e.done = (j == mw); end
        push(e, j == mw);
      end
      if (o == 6'b100011) begin
        e = '0; e.rw = 1; e.m2r = 1; e.done = 1; e.st = 9; push(e, 1'($urandom));
      end
    end else if (o inside {6'b000100, 6'b000101, 6'b000110, 6'b000001}) begin
      push(e, 1'($urandom));
      e = '0; e.a = 1; e.aop = 3'b001; e.pcs = 1; e.done = 1; e.st = 10;
      case (o)
        6'b000100: e.pcw = z;
        6'b000101: e.pcw = !z;
        6'b000110: e.pcw = z | n;
        default:   e.pcw = n;
      endcase
      push(e, 1'($urandom));
    end else begin
      e.done = 1; e.ill = 1; push(e, 1'($urandom));
    end
  endtask

  // Drive one instruction; rst_at >= 0 asserts reset during that trace cycle and abandons the rest
  task automatic run(input logic [5:0] o, f, input int fw, mw, input logic z, n, input int rst_at);
    ov_t e;
    int k = 0;
    op = o; fn = f; zero = z; neg = n;
    exp_q.delete(); rdy_q.delete();
    build(o, f, fw, mw, z, n);
    n_instr++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rdy = rdy_q.pop_front();
      if (k == rst_at) begin rst = 1'b1; e = '0; end
      @(negedge clk);
      check($sformatf("st%0d_cyc%0d", e.st, k), e);
      @(posedge clk); #1;
      if (k == rst_at) begin rst = 1'b0; exp_q.delete(); rdy_q.delete(); end
      k++;
    end
  endtask

  initial begin
    logic [5:0] ops [14];
    ops = '{6'h00, 6'h08, 6'h0b, 6'h0f, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h06, 6'h01,
            6'h02, 6'h03, 6'h3f};
    rst = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); check("reset", '0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    run(6'h00, 6'h20, 0, 0, 0, 0, -1);   // add
    run(6'h23, 6'h00, 0, 3, 0, 0, -1);   // lw with 3 wait cycles
    run(6'h04, 6'h00, 0, 0, 1, 0, -1);   // beq taken
    run(6'h05, 6'h00, 0, 0, 1, 0, -1);   // bne not taken
    run(6'h03, 6'h00, 0, 0, 0, 0, -1);   // jal
    run(6'h00, 6'h08, 0, 0, 0, 0, -1);   // jr
    run(6'h3f, 6'h00, 0, 0, 0, 0, -1);   // illegal
    run(6'h2b, 6'h00, 0, 2, 0, 0, 4);    // sw abandoned by reset in MEM_WR
    run(6'h0d, 6'h00, 1, 0, 0, 0, -1);   // ori after reset, one fetch wait
    for (int i = 0; i < 80; i++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      f = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run(o, f, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 1'($urandom), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset CPU: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back, driving every datapath select, enable and ALU-operation line. It replaces per-instruction single-cycle decode and lets one ALU and one unified memory be shared across cycles. Memory accesses use a ready handshake, so variable-latency memory stalls the sequence.

## Interface
- No parameters.
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_op_i  in  6  opcode from the instruction register; valid from DECODE until the next FETCH
- funct_i  in  6  funct field from the instruction register; same validity
- zero_i  in  1  ALU result == 0
- neg_i  in  1  ALU result bit 31
- mem_ready_i  in  1  memory completes the current read/write this cycle
- pc_write_o  out  1  PC load enable
- pc_src_o  out  2  0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = {PC[31:28], target, 00}, 3 = rs
- ir_write_o  out  1  IR load enable
- iord_o  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read_o, mem_write_o  out  1 each  memory strobes
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  0 = rt, 1 = 4, 2 = ext(imm), 3 = ext(imm)<<2
- se_o  out  1  1 = sign-extend, 0 = zero-extend
- alu_op_o  out  3  000 add, 001 sub, 010 funct-decoded, 011 lui, 100 or, 110 sltu
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- state_o  out  4  current state encoding
- instr_done_o  out  1  one-cycle pulse in the last state of each instruction
- illegal_o  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11. Encodings 12-15 go to FETCH.
- FETCH: mem_read = 1, iord = 0, a = 0, b = 1, add.
  - While mem_ready_i = 0: hold FETCH with pc_write = ir_write = 0.
  - On mem_ready_i = 1: pc_write = ir_write = 1, pc_src = 0, then go to DECODE.
- DECODE: a = 0, b = 3, se = 1, add (precomputes the branch target). Dispatch:
  - op 000000 with funct 001000 (jr) -> JUMP
  - other op 000000 -> EXEC_R
  - 001000, 001011, 001111, 001101 -> EXEC_I
  - 100011, 101011 -> ADDR
  - 000100, 000101, 000110, 000001 -> BRANCH
  - 000010, 000011 -> JUMP
  - anything else -> FETCH with illegal_o = 1 and instr_done_o = 1
- EXEC_R: a = 1, b = 0, alu_op = 010, then WB_R.
- WB_R: reg_write = 1, reg_dst = 1, m2r = 0, done.
- EXEC_I: a = 1, b = 2, then WB_I.
  - addi: add, se = 1
  - sltiu: sltu, se = 1
  - lui: lui, se = 1
  - ori: or, se = 0
- WB_I: reg_write = 1, reg_dst = 0, m2r = 0, done; ALU inputs held as in EXEC_I.
- ADDR: a = 1, b = 2, se = 1, add, then MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read = 1, iord = 1. Wait for ready, then WB_MEM.
- MEM_WR: mem_write = 1, iord = 1. Wait for ready, then done and FETCH.
- WB_MEM: reg_write = 1, reg_dst = 0, m2r = 1, done. The datapath captures MDR every cycle.
- BRANCH: a = 1, b = 0, sub, pc_src = 1, done. pc_write is the taken condition:
  - beq: zero_i
  - bne: !zero_i
  - ble: zero_i | neg_i
  - bltz: neg_i (rt field is $0)
- JUMP: pc_write = 1, done.
  - j: pc_src = 2
  - jal: pc_src = 2, plus reg_write = 1, reg_dst = 2, m2r = 2 (PC already holds PC+4)
  - jr: pc_src = 3
- After any "done" state the next state is FETCH.
- Outputs not listed for a state are 0.

## Timing
- Outputs are combinational from the state register and the instruction fields (Moore with respect to the sequence).
- pc_write_o additionally depends on zero_i, neg_i and mem_ready_i in the same cycle.
- rst_i = 1 at an edge: the state becomes FETCH. While rst_i = 1, every output is forced to 0, including state_o.
  - Reset mid-instruction abandons it; no write strobe is issued after the reset edge.
- Latency with memory ready on first request:
  - lw: 5 cycles
  - R-type, I-type, sw: 4 cycles
  - branch, j, jal, jr: 3 cycles
  - illegal opcode: 2 cycles
- Each memory wait cycle adds 1 cycle. Strobes and iord stay stable while waiting.
- instr_done_o is high exactly once per instruction; illegal_o implies instr_done_o in the same cycle.

## Test plan
- Reset for 2 cycles with mem_ready_i = 1 -> all outputs 0 during reset; FETCH next with mem_read = 1, pc_write = ir_write = 1.
- add (op 0, funct 100000) with ready = 1 -> states 0, 1, 2, 7; reg_write = 1 and reg_dst = 1 only in state 7; done on cycle 4.
- lw with mem_ready_i low for 3 cycles in MEM_RD -> state 5 held 4 cycles with mem_read = 1 and iord = 1, then 9 with m2r = 1; total 8 cycles.
- beq with zero_i = 1, then bne with zero_i = 1 -> pc_write = 1 with pc_src = 1 for beq; pc_write = 0 for bne; both take 3 cycles.
- jal, then jr -> jal: pc_src = 2, reg_write = 1, reg_dst = 2, m2r = 2; jr: pc_src = 3, reg_write = 0.
- op 111111 -> illegal_o and instr_done_o pulse in DECODE, return to FETCH. Also: rst_i asserted in MEM_WR -> mem_write drops to 0 and the next state is FETCH.
